// File: rtl/leaf_out_arbiter.sv
// leaf_out_arbiter: credit-gated round-robin output stage for a leaf shell.
// Collects NUM_OUT_PORTS user valid/ack streams and registers one
// packetised word per cycle toward the BFT.
// Optional feature macro: LEAF_ARB_SEQ_EN (per-port sequence counters;
// when undefined the seq field of every packet is constant 0).
module leaf_out_arbiter #(
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int PACKET_BITS           = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS,
  parameter int NUM_OUT_PORTS         = 5,
  parameter int CREDIT_BITS           = 8,
  parameter int CREDIT_INIT           = 64,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]  din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]               vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]               ack_interface2user,
  input  logic [NUM_OUT_PORTS*NUM_LEAF_BITS-1:0] dest_leaf_cfg,
  input  logic [NUM_OUT_PORTS*NUM_PORT_BITS-1:0] dest_port_cfg,
  input  logic                                   credit_update_vld,
  input  logic [NUM_PORT_BITS-1:0]               credit_update_port,
  input  logic                                   bft_ready,
  input  logic                                   resend,
  output logic [PACKET_BITS-1:0]                 dout_leaf_interface2bft
);

  localparam int          RR_BITS    = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam int unsigned CREDIT_MAX = (1 << CREDIT_BITS) - 1;

  logic [PACKET_BITS-1:0]   pkt_q, pkt_d;
  logic [RR_BITS-1:0]       rr_q, rr_d;
  logic [CREDIT_BITS-1:0]   credit_q [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   credit_d [NUM_OUT_PORTS];
`ifdef LEAF_ARB_SEQ_EN
  logic [NUM_ADDR_BITS-1:0] seq_q [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] seq_d [NUM_OUT_PORTS];
`endif

  logic                     pkt_valid, drain, can_load;
  logic [NUM_OUT_PORTS-1:0] elig, grant_oh, upd_hit;
  logic                     grant_vld;
  logic [RR_BITS-1:0]       grant_idx;
  int unsigned              cand;
  logic [NUM_LEAF_BITS-1:0] sel_leaf;
  logic [NUM_PORT_BITS-1:0] sel_port;
  logic [NUM_ADDR_BITS-1:0] sel_seq;
  logic [PAYLOAD_BITS-1:0]  sel_data;
  logic [31:0]              credit_sum;

  // Output-register status and per-port eligibility; reset blocks grants so
  // a word offered during reset is never acked.
  always_comb begin
    pkt_valid = pkt_q[PACKET_BITS-1];
    drain     = pkt_valid & bft_ready & ~resend;
    can_load  = ~reset & ~resend & (~pkt_valid | drain);
    elig      = '0;
    upd_hit   = '0;
    for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
      elig[i]    = vld_user2interface[i] & (credit_q[i] != '0) & can_load;
      upd_hit[i] = credit_update_vld & (credit_update_port == NUM_PORT_BITS'(i));
    end
  end

  // Round-robin search starting at rr, wrapping once through all ports.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_OUT_PORTS; k++) begin
      cand = int'(rr_q) + k;
      if (cand >= NUM_OUT_PORTS) cand = cand - NUM_OUT_PORTS;
      if (!grant_vld && elig[cand[RR_BITS-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[RR_BITS-1:0];
      end
    end
  end

  // Grant decode: ack, pointer advance and the fields of the winning port.
  always_comb begin
    grant_oh = '0;
    sel_leaf = '0;
    sel_port = '0;
    sel_seq  = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
      if (grant_vld && grant_idx == RR_BITS'(i)) begin
        grant_oh[i] = 1'b1;
        sel_leaf    = dest_leaf_cfg[i*NUM_LEAF_BITS +: NUM_LEAF_BITS];
        sel_port    = dest_port_cfg[i*NUM_PORT_BITS +: NUM_PORT_BITS];
        sel_data    = din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
`ifdef LEAF_ARB_SEQ_EN
        sel_seq     = seq_q[i];
`endif
      end
    end
    ack_interface2user = grant_oh;
    rr_d = rr_q;
    if (grant_vld)
      rr_d = (grant_idx == RR_BITS'(NUM_OUT_PORTS - 1)) ? '0 : grant_idx + 1'b1;
  end

  // Next packet: load on grant, otherwise clear only the valid bit on drain.
  always_comb begin
    pkt_d = pkt_q;
    if (grant_vld)
      pkt_d = {1'b1, sel_leaf, sel_port, sel_seq, sel_data};
    else if (drain)
      pkt_d[PACKET_BITS-1] = 1'b0;
  end

  // Credit counters: the update is applied even during resend so returned
  // freespace is never lost; grant and update combine before saturation.
  always_comb begin
    credit_sum = '0;
    for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
      credit_sum = 32'(credit_q[i]);
      if (upd_hit[i])  credit_sum = credit_sum + 32'(FREESPACE_UPDATE_SIZE);
      if (grant_oh[i]) credit_sum = credit_sum - 32'd1;
      credit_d[i] = (credit_sum > 32'(CREDIT_MAX)) ? CREDIT_BITS'(CREDIT_MAX)
                                                   : credit_sum[CREDIT_BITS-1:0];
    end
  end

  // Packet, pointer and credit state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_q <= '0;
      rr_q  <= '0;
      for (int unsigned i = 0; i < NUM_OUT_PORTS; i++)
        credit_q[i] <= CREDIT_BITS'(CREDIT_INIT);
    end else begin
      pkt_q <= pkt_d;
      rr_q  <= rr_d;
      for (int unsigned i = 0; i < NUM_OUT_PORTS; i++)
        credit_q[i] <= credit_d[i];
    end
  end

`ifdef LEAF_ARB_SEQ_EN
  // Per-port sequence counters advance on each grant and wrap naturally.
  always_comb begin
    for (int unsigned i = 0; i < NUM_OUT_PORTS; i++)
      seq_d[i] = grant_oh[i] ? seq_q[i] + 1'b1 : seq_q[i];
  end

  // Sequence counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) seq_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) seq_q[i] <= seq_d[i];
    end
  end
`endif

  // Resend blanks the output without disturbing the held packet.
  always_comb begin
    dout_leaf_interface2bft = resend ? '0 : pkt_q;
  end

endmodule
